// File: rtl/cordic_sincos.sv
// Iterative CORDIC rotation-mode engine producing cos(theta) and sin(theta)
// in signed fixed point, with start/done/clk_en handshake and a busy flag.
module cordic_sincos #(
   parameter int WIDTH = 23,
   parameter int FRAC  = 21,
   parameter int ITERS = 16,
   parameter int GUARD = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en,
   input  logic             start,
   input  logic [WIDTH-1:0] fixedPoint_theta,
   output logic [WIDTH-1:0] fixedPoint_cos,
   output logic [WIDTH-1:0] fixedPoint_sin,
   output logic             busy,
   output logic             done
);

   localparam int IW        = WIDTH + GUARD + 1;
   localparam int SCALE     = FRAC + GUARD;
   localparam int IDXW      = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam int ITERS_MAX = (FRAC + 1 < 24) ? FRAC + 1 : 24;

   generate
      if (ITERS < 4 || ITERS > ITERS_MAX) begin : g_bad_iters
         $error("cordic_sincos: ITERS out of legal range");
      end
   endgenerate

   function automatic real scale_f();
      real s;
      s = 1.0;
      for (int unsigned k = 0; k < SCALE; k++) s = s * 2.0;
      return s;
   endfunction

   // atan(2^-i) by power series; converges fast for i >= 1, i = 0 is pi/4
   function automatic real atan_pow2(input int unsigned i);
      real x, term, acc;
      if (i == 0) return 0.78539816339744830962;
      x = 1.0;
      for (int unsigned k = 0; k < i; k++) x = x / 2.0;
      acc  = 0.0;
      term = x;
      for (int unsigned n = 0; n < 40; n++) begin
         if (n % 2 == 0) acc = acc + term / real'(2 * n + 1);
         else            acc = acc - term / real'(2 * n + 1);
         term = term * x * x;
      end
      return acc;
   endfunction

   // Gain = prod 1/sqrt(1 + 4^-i) over the iterations actually performed
   function automatic real cordic_gain();
      real k2, p, g;
      k2 = 1.0;
      p  = 1.0;
      for (int unsigned i = 0; i < ITERS; i++) begin
         k2 = k2 / (1.0 + p);
         p  = p / 4.0;
      end
      g = 1.0;
      for (int unsigned n = 0; n < 40; n++) g = 0.5 * (g + k2 / g);
      return g;
   endfunction

   function automatic logic [ITERS*IW-1:0] build_atan();
      logic [ITERS*IW-1:0] t;
      t = '0;
      for (int unsigned i = 0; i < ITERS; i++)
         t[i*IW +: IW] = IW'(longint'(atan_pow2(i) * scale_f()));
      return t;
   endfunction

   localparam logic [ITERS*IW-1:0] ATAN_TBL = build_atan();
   localparam logic signed [IW-1:0] K_INIT  = IW'(longint'(cordic_gain() * scale_f()));

   function automatic logic [WIDTH-1:0] trunc_sat(input logic signed [IW-1:0] v);
      logic signed [WIDTH:0] t;
      t = v[IW-1:GUARD];
      if (t[WIDTH] != t[WIDTH-1])
         return t[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      return t[WIDTH-1:0];
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROTATE,
      ST_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic signed [IW-1:0]   x_q, y_q, z_q;
   logic signed [IW-1:0]   x_d, y_d, z_d;
   logic [IDXW-1:0]        i_q, i_d;
   logic [WIDTH-1:0]       cos_d, sin_d;
   logic                   busy_d, done_d;
   logic signed [IW-1:0]   x_sh, y_sh, atan_i, theta_ext;
   logic signed [IW-1:0]   atan_rom [ITERS];

   for (genvar g = 0; g < ITERS; g++) begin : g_rom
      assign atan_rom[g] = ATAN_TBL[g*IW +: IW];
   end

   assign theta_ext = IW'($signed(fixedPoint_theta));
   assign x_sh      = x_q >>> i_q;
   assign y_sh      = y_q >>> i_q;
   assign atan_i    = atan_rom[i_q];

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      i_d     = i_q;
      cos_d   = fixedPoint_cos;
      sin_d   = fixedPoint_sin;
      busy_d  = busy;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               x_d     = K_INIT;
               y_d     = '0;
               z_d     = theta_ext <<< GUARD;
               i_d     = '0;
               busy_d  = 1'b1;
               state_d = ST_ROTATE;
            end
         end
         ST_ROTATE: begin
            if (!z_q[IW-1]) begin
               x_d = x_q - y_sh;
               y_d = y_q + x_sh;
               z_d = z_q - atan_i;
            end else begin
               x_d = x_q + y_sh;
               y_d = y_q - x_sh;
               z_d = z_q + atan_i;
            end
            i_d = i_q + IDXW'(1);
            // busy drops with the final rotation, so it spans exactly ITERS cycles
            if (i_q == IDXW'(ITERS - 1)) begin
               busy_d  = 1'b0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            cos_d   = trunc_sat(x_q);
            sin_d   = trunc_sat(y_q);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         x_q            <= '0;
         y_q            <= '0;
         z_q            <= '0;
         i_q            <= '0;
         fixedPoint_cos <= '0;
         fixedPoint_sin <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else if (clk_en) begin
         state_q        <= state_d;
         x_q            <= x_d;
         y_q            <= y_d;
         z_q            <= z_d;
         i_q            <= i_d;
         fixedPoint_cos <= cos_d;
         fixedPoint_sin <= sin_d;
         busy           <= busy_d;
         done           <= done_d;
      end
   end

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed table-driven bench for cordic_sincos at default parameters, with
// hand sequences for clk_en gating, back-to-back starts and mid-run reset.
module tb_cordic_sincos;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        start;
   logic [22:0] theta;
   logic [22:0] fp_cos;
   logic [22:0] fp_sin;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;

   localparam int TOL = 128;

   cordic_sincos #(.WIDTH(23), .FRAC(21), .ITERS(16), .GUARD(3)) dut (
      .clk              (clk),
      .reset            (reset),
      .clk_en           (clk_en),
      .start            (start),
      .fixedPoint_theta (theta),
      .fixedPoint_cos   (fp_cos),
      .fixedPoint_sin   (fp_sin),
      .busy             (busy),
      .done             (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [22:0] th;
      bit          toggle;
      int          poke;
      bit          b2b;
      int          cos_exp;
      int          sin_exp;
   } vec_t;

   vec_t vq[$];

   task automatic add_vec(input string name, input logic [22:0] th, input bit toggle,
                          input int poke, input bit b2b, input int ce, input int se);
      vec_t v;
      v.name = name; v.th = th; v.toggle = toggle; v.poke = poke;
      v.b2b = b2b; v.cos_exp = ce; v.sin_exp = se;
      vq.push_back(v);
   endtask

   task automatic check_tol(input string name, input int act, input int exp, input int tol);
      n_checks++;
      if (act > exp + tol || act < exp - tol) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (+/- %0d)", name, act, exp, tol);
      end
   endtask

   function automatic bit en_pat(input int k);
      return (k % 4 == 0) || (k % 4 == 3);
   endfunction

   // Pulses start on one enabled edge, then runs until done (bounded).
   task automatic do_conv(input logic [22:0] th, input bit toggle, input int poke,
                          output int c, output int s, output int lat, output int bcnt,
                          output bit acc_busy, output bit acc_done, output int acc_cos,
                          output bit tmo);
      int k;
      k = 0; lat = 0; bcnt = 0;
      theta = th; start = 1'b1; clk_en = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      acc_busy = busy;
      acc_done = done;
      acc_cos  = int'($signed(fp_cos));
      if (busy) bcnt++;
      while (!done && k < 200) begin
         clk_en = toggle ? en_pat(k) : 1'b1;
         if (k == poke) begin start = 1'b1; theta = 23'h0; end
         else start = 1'b0;
         @(posedge clk); #1;
         if (clk_en) begin
            lat++;
            if (busy) bcnt++;
         end
         k++;
      end
      start  = 1'b0;
      clk_en = 1'b1;
      tmo    = !done;
      c      = int'($signed(fp_cos));
      s      = int'($signed(fp_sin));
   endtask

   initial begin
      int  c, s, lat, bcnt, acc_cos, prev_cos;
      bit  acc_busy, acc_done, tmo, seen;

      add_vec("pos1",      23'h200000, 1'b0, -1, 1'b0, 1133102,  1764718);
      add_vec("zero",      23'h000000, 1'b0, -1, 1'b0, 2097152,  0);
      add_vec("neg1",      23'h600000, 1'b0, -1, 1'b0, 1133102, -1764718);
      add_vec("pos1_en",   23'h200000, 1'b1, -1, 1'b0, 1133102,  1764718);
      add_vec("pos1_poke", 23'h200000, 1'b0,  5, 1'b0, 1133102,  1764718);
      add_vec("half_b2b",  23'h100000, 1'b0, -1, 1'b1, 1840389,  1005416);

      reset = 1'b1; clk_en = 1'b1; start = 1'b0; theta = '0;
      repeat (2) @(posedge clk);
      #1;
      check_tol("rst_busy", int'(busy), 0, 0);
      check_tol("rst_done", int'(done), 0, 0);
      check_tol("rst_cos",  int'($signed(fp_cos)), 0, 0);
      check_tol("rst_sin",  int'($signed(fp_sin)), 0, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      prev_cos = 0;
      foreach (vq[v]) begin
         if (vq[v].b2b) check_tol({vq[v].name, "_pre_done"}, int'(done), 1, 0);
         do_conv(vq[v].th, vq[v].toggle, vq[v].poke, c, s, lat, bcnt,
                 acc_busy, acc_done, acc_cos, tmo);
         check_tol({vq[v].name, "_timeout"},  int'(tmo), 0, 0);
         check_tol({vq[v].name, "_acc_busy"}, int'(acc_busy), 1, 0);
         check_tol({vq[v].name, "_acc_done"}, int'(acc_done), 0, 0);
         check_tol({vq[v].name, "_hold_out"}, acc_cos, prev_cos, (v == 0) ? 0 : TOL);
         check_tol({vq[v].name, "_latency"},  lat, 17, 0);
         check_tol({vq[v].name, "_busy_cyc"}, bcnt, 16, 0);
         check_tol({vq[v].name, "_cos"},      c, vq[v].cos_exp, TOL);
         check_tol({vq[v].name, "_sin"},      s, vq[v].sin_exp, TOL);
         prev_cos = vq[v].cos_exp;
         if (vq[v].toggle) begin
            clk_en = 1'b0;
            @(posedge clk); #1;
            check_tol("en_done_hold1", int'(done), 1, 0);
            @(posedge clk); #1;
            check_tol("en_done_hold2", int'(done), 1, 0);
            check_tol("en_cos_hold", int'($signed(fp_cos)), vq[v].cos_exp, TOL);
            clk_en = 1'b1;
            @(posedge clk); #1;
            check_tol("en_done_clear", int'(done), 0, 0);
         end
      end

      // Abort on the 8th rotation cycle; reset asserted with clk_en low
      theta = 23'h200000; start = 1'b1; clk_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check_tol("mid_busy", int'(busy), 1, 0);
      reset = 1'b1; clk_en = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; clk_en = 1'b1;
      check_tol("abort_busy", int'(busy), 0, 0);
      check_tol("abort_done", int'(done), 0, 0);
      check_tol("abort_cos",  int'($signed(fp_cos)), 0, 0);
      check_tol("abort_sin",  int'($signed(fp_sin)), 0, 0);
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1'b1;
      end
      check_tol("abort_no_done", int'(seen), 0, 0);

      do_conv(23'h000000, 1'b0, -1, c, s, lat, bcnt, acc_busy, acc_done, acc_cos, tmo);
      check_tol("post_rst_timeout", int'(tmo), 0, 0);
      check_tol("post_rst_latency", lat, 17, 0);
      check_tol("post_rst_cos", c, 2097152, TOL);
      check_tol("post_rst_sin", s, 0, TOL);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cordic_sincos.md
Name: cordic_sincos

Overview:
- Iterative, parametrised CORDIC rotation engine in rotation mode.
- Takes a signed fixed-point angle in radians and returns both cos(theta) and sin(theta) in the same format.
- Successor to the single-output cosine core, with the same start/done/clk_en handshake.
- Adds configurable width, precision and iteration count, a sine output and a busy flag.

Parameters:
- WIDTH, 23: total bits of theta, cos_out and sin_out; signed two's complement.
- FRAC, 21: fractional bits, so 1.0 = 2^FRAC (default format Q2.21, 1.0 = 23'h200000).
- ITERS, 16: micro-rotations per conversion. Legal range 4..min(FRAC+1, 24); elaboration error outside it.
- GUARD, 3: extra LSBs carried internally on x, y and z; truncated on output.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high.
- clk_en, input, 1: global enable. When low, every register holds, including done and the outputs.
- start, input, 1: request a conversion. Sampled only when IDLE and clk_en=1.
- fixedPoint_theta, input, WIDTH: angle in radians. Valid range |theta| <= 1.0; outside this range results are unspecified.
- fixedPoint_cos, output, WIDTH: cos(theta) result.
- fixedPoint_sin, output, WIDTH: sin(theta) result.
- busy, output, 1: high from the accepted start through the final rotation.
- done, output, 1: result-valid pulse.

Behaviour:
- All registers advance only on a rising clk edge with clk_en=1. reset overrides clk_en.
- Reset values: state=IDLE, busy=0, done=0, fixedPoint_cos=0, fixedPoint_sin=0, internal x/y/z/i=0.
- IDLE:
  - On start=1, latch z=theta<<GUARD, x=K, y=0, i=0; set busy=1 and go to ROTATE.
  - K = round(0.6072529350 * 2^(FRAC+GUARD)), computed at elaboration for the given ITERS.
- ROTATE, each enabled cycle:
  - d = (z >= 0) ? +1 : -1.
  - x <= x - d*(y>>>i); y <= y + d*(x>>>i); z <= z - d*ATAN[i]; i <= i+1.
  - Shifts are arithmetic. Internal width is WIDTH+GUARD+1 (one extra integer bit against overflow).
  - ATAN[i] = round(atan(2^-i) * 2^(FRAC+GUARD)), held in an elaboration-time constant table sized ITERS.
  - After the rotation with i=ITERS-1, go to DONE.
- DONE, one enabled cycle:
  - fixedPoint_cos <= x>>>GUARD, fixedPoint_sin <= y>>>GUARD (truncate, then saturate to the WIDTH signed range).
  - done <= 1, busy <= 0, return to IDLE.
- done is high for exactly one enabled cycle. If clk_en falls while done=1, done stays high until the next enabled edge.
- Latency: start accepted at enabled edge N; done high after enabled edge N+ITERS+1 (default 17 enabled cycles).
- Throughput: one conversion per ITERS+2 enabled cycles. start is accepted in the same enabled edge that clears done.
- start while busy: ignored. No queuing; theta changes during ROTATE have no effect.
- Outputs hold their last result until the next DONE. They are not cleared at start.
- reset mid-conversion: abort, return to reset values next edge, no done pulse.
- Accuracy at defaults for |theta| <= 1.0: |error| <= 2^-14 (128 LSB) on both outputs against an ideal reference.

Test Plan:
- theta=23'h200000 (1.0), start held for one cycle, clk_en=1 -> done pulses exactly 17 cycles later.
  - cos within 128 of 1133102 (0.540302).
  - sin within 128 of 1764718 (0.841471).
  - busy high for 16 cycles.
- theta=0 -> cos within 128 of 2097152, sin within 128 of 0.
- theta=-1.0 (23'h600000) -> cos matches the +1.0 case within 2 LSB; sin within 128 of -1764718.
- clk_en toggling 1,0,0,1 throughout the 1.0 conversion -> identical results.
  - done occurs after 17 enabled cycles.
  - done remains high during the disabled cycles following it.
- start re-asserted with theta=0 during ROTATE of the 1.0 conversion -> ignored; results correspond to 1.0.
  - Then a back-to-back start on the done cycle with theta=0.5 -> accepted.
  - Result cos ~1840389, sin ~1005416 (within 128).
- reset pulsed at cycle 8 of a conversion -> busy=0, done=0, outputs 0 next edge, no done pulse afterwards.
  - A new start then completes normally.
